// File: rtl/up_timer_pkg.sv
// Shared definitions for the prescaled up-counting timer.
package up_timer_pkg;

    typedef enum logic {TMR_IDLE, TMR_RUN} tmr_state_t;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/up_timer_if.sv
// Control/status bundle between a timer client (master) and the timer (slave).
interface up_timer_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PS_WIDTH = 4
) ();

    logic                start;
    logic                stop;
    logic                pause;
    logic                repeat_mode;
    logic [WIDTH-1:0]    limit;
    logic [PS_WIDTH-1:0] prescale;
    logic [WIDTH-1:0]    count;
    logic                tick;
    logic                done;
    logic                busy;

    modport master (
        output start, stop, pause, repeat_mode, limit, prescale,
        input  count, tick, done, busy
    );

    modport slave (
        input  start, stop, pause, repeat_mode, limit, prescale,
        output count, tick, done, busy
    );

endinterface

// File: rtl/up_timer_tick_prescaler.sv
// Step divider: strobes o_step on every (i_div+1)-th enabled clock.
module up_timer_tick_prescaler #(
    parameter int unsigned PS_WIDTH = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clear,
    input  logic                i_enable,
    input  logic [PS_WIDTH-1:0] i_div,
    output logic                o_step
);

    logic [PS_WIDTH-1:0] r_cnt;

    assign o_step = i_enable && (r_cnt == i_div);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || o_step) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/up_timer.sv
// Prescaled up-counting timer: counts 0 -> limit, one-shot or auto-repeat, with tick/done pulses.
module up_timer
    import up_timer_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PS_WIDTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    up_timer_if.slave  bus
);

    logic [0:0]          r_state;
    logic [WIDTH-1:0]    r_count;
    logic [WIDTH-1:0]    r_limit;
    logic [PS_WIDTH-1:0] r_prescale;
    logic                r_repeat;
    logic                r_tick;
    logic                r_done;

    logic                w_run;
    logic                w_ps_en;
    logic                w_step;
    logic [WIDTH-1:0]    w_last;

    assign w_run   = (r_state == ST_RUN);
    assign w_ps_en = w_run && !bus.pause && !bus.start && !bus.stop;
    // Limit 0 wraps to all-ones so the run covers the full 2^WIDTH range.
    assign w_last  = r_limit - {{(WIDTH-1){1'b0}}, 1'b1};

    up_timer_tick_prescaler #(
        .PS_WIDTH (PS_WIDTH)
    ) u_prescaler (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (bus.start),
        .i_enable (w_ps_en),
        .i_div    (r_prescale),
        .o_step   (w_step)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_limit    <= '0;
            r_prescale <= '0;
            r_repeat   <= 1'b0;
            r_tick     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_done <= 1'b0;
            if (bus.start) begin
                r_state    <= ST_RUN;
                r_count    <= '0;
                r_limit    <= bus.limit;
                r_prescale <= bus.prescale;
                r_repeat   <= bus.repeat_mode;
            end else if (bus.stop) begin
                r_state <= ST_IDLE;
            end else if (w_step) begin
                r_tick <= 1'b1;
                if (r_count == w_last) begin
                    r_done <= 1'b1;
                    if (r_repeat) begin
                        r_count <= '0;
                    end else begin
                        r_count <= r_limit;
                        r_state <= ST_IDLE;
                    end
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign bus.count = r_count;
    assign bus.tick  = r_tick;
    assign bus.done  = r_done;
    assign bus.busy  = w_run;

endmodule

// File: tb/tb_up_timer.sv
// Scoreboard bench for up_timer: stimulus pushes expected ticks, monitors pop and compare.
module tb_up_timer;

    typedef struct {
        int cyc;
        int cnt;
        bit done;
        bit busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q8[$];
    exp_t q4[$];

    up_timer_if #(.WIDTH(8), .PS_WIDTH(4)) if8 ();
    up_timer_if #(.WIDTH(4), .PS_WIDTH(4)) if4 ();

    up_timer #(.WIDTH(8), .PS_WIDTH(4)) u_dut8 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if8)
    );

    up_timer #(.WIDTH(4), .PS_WIDTH(4)) u_dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push8(input int c, input int cnt, input bit d, input bit b);
        exp_t e;
        e.cyc = c; e.cnt = cnt; e.done = d; e.busy = b;
        q8.push_back(e);
    endfunction

    function automatic void push4(input int c, input int cnt, input bit d, input bit b);
        exp_t e;
        e.cyc = c; e.cnt = cnt; e.done = d; e.busy = b;
        q4.push_back(e);
    endfunction

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Start lands on the next posedge; cs is the cycle stamp seen right after that edge.
    task automatic start_run(input bit sel, input int lim, input int ps, input bit rep,
                             output int cs);
        @(negedge clk);
        if (sel) begin
            if4.limit = 4'(lim); if4.prescale = 4'(ps); if4.repeat_mode = rep; if4.start = 1'b1;
        end else begin
            if8.limit = 8'(lim); if8.prescale = 4'(ps); if8.repeat_mode = rep; if8.start = 1'b1;
        end
        cs = cyc + 1;
        @(negedge clk);
        if4.start = 1'b0;
        if8.start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (if8.tick) begin
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_tick8: got tick=1 count=%0d expected no tick", if8.count);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("tick8_cycle", cyc, e.cyc);
                chk("tick8_count", int'(if8.count), e.cnt);
                chk("tick8_done", int'(if8.done), int'(e.done));
                chk("tick8_busy", int'(if8.busy), int'(e.busy));
            end
        end else if (if8.done) begin
            total++; bad++;
            $display("FAIL done8_without_tick: got done=1 tick=0 expected done=0");
        end
        if (if4.tick) begin
            if (q4.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_tick4: got tick=1 count=%0d expected no tick", if4.count);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("tick4_cycle", cyc, e.cyc);
                chk("tick4_count", int'(if4.count), e.cnt);
                chk("tick4_done", int'(if4.done), int'(e.done));
                chk("tick4_busy", int'(if4.busy), int'(e.busy));
            end
        end else if (if4.done) begin
            total++; bad++;
            $display("FAIL done4_without_tick: got done=1 tick=0 expected done=0");
        end
    end

    initial begin
        int cs;
        int cs2;
        if8.start = 0; if8.stop = 0; if8.pause = 0; if8.repeat_mode = 0;
        if8.limit = '0; if8.prescale = '0;
        if4.start = 0; if4.stop = 0; if4.pause = 0; if4.repeat_mode = 0;
        if4.limit = '0; if4.prescale = '0;
        repeat (3) @(negedge clk);
        chk("reset_count", int'(if8.count), 0);
        chk("reset_busy", int'(if8.busy), 0);
        chk("reset_tick", int'(if8.tick), 0);
        chk("reset_done", int'(if8.done), 0);
        rst_n = 1'b1;

        // 1: reset mid-run
        start_run(0, 10, 0, 0, cs);
        for (int k = 1; k <= 5; k++) push8(cs + k, k, 0, 1);
        wait_cyc(cs + 5);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_count", int'(if8.count), 0);
        chk("midreset_busy", int'(if8.busy), 0);
        chk("midreset_tick", int'(if8.tick), 0);
        chk("midreset_done", int'(if8.done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 2: one-shot, limit 3; limit input change mid-run must be ignored
        start_run(0, 3, 0, 0, cs);
        if8.limit = 8'd9;
        push8(cs + 1, 1, 0, 1);
        push8(cs + 2, 2, 0, 1);
        push8(cs + 3, 3, 1, 0);
        wait_cyc(cs + 6);
        chk("oneshot_hold_count", int'(if8.count), 3);
        chk("oneshot_busy", int'(if8.busy), 0);

        // 3: prescale 2, 5-cycle pause after first tick
        start_run(0, 4, 2, 0, cs);
        push8(cs + 3, 1, 0, 1);
        push8(cs + 11, 2, 0, 1);
        push8(cs + 14, 3, 0, 1);
        push8(cs + 17, 4, 1, 0);
        wait_cyc(cs + 3);
        if8.pause = 1'b1;
        repeat (5) @(negedge clk);
        if8.pause = 1'b0;
        wait_cyc(cs + 20);

        // 4: auto-repeat, limit 2
        start_run(0, 2, 0, 1, cs);
        for (int k = 1; k <= 6; k++) push8(cs + k, k % 2, (k % 2) == 0, 1);
        wait_cyc(cs + 6);
        chk("repeat_busy", int'(if8.busy), 1);
        if8.stop = 1'b1;
        @(negedge clk);
        if8.stop = 1'b0;
        chk("repeat_stop_busy", int'(if8.busy), 0);

        // 5: start+stop restarts, then stop alone holds count
        start_run(0, 20, 0, 0, cs);
        for (int k = 1; k <= 5; k++) push8(cs + k, k, 0, 1);
        wait_cyc(cs + 5);
        if8.start = 1'b1;
        if8.stop = 1'b1;
        cs2 = cyc + 1;
        @(negedge clk);
        if8.start = 1'b0;
        if8.stop = 1'b0;
        chk("startstop_count", int'(if8.count), 0);
        chk("startstop_busy", int'(if8.busy), 1);
        for (int k = 1; k <= 5; k++) push8(cs2 + k, k, 0, 1);
        wait_cyc(cs2 + 5);
        if8.stop = 1'b1;
        @(negedge clk);
        if8.stop = 1'b0;
        chk("stop_count", int'(if8.count), 5);
        chk("stop_busy", int'(if8.busy), 0);
        repeat (4) @(negedge clk);
        chk("stop_hold_count", int'(if8.count), 5);

        // 6: WIDTH=4 full range, limit 0
        start_run(1, 0, 0, 0, cs);
        for (int k = 1; k <= 15; k++) push4(cs + k, k, 0, 1);
        push4(cs + 16, 0, 1, 0);
        wait_cyc(cs + 19);
        chk("full_count", int'(if4.count), 0);
        chk("full_busy", int'(if4.busy), 0);

        chk("q8_drained", q8.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
